tag_free_list: RTL and testbench
================================

# tag_free_list

Parametrised physical-register tag allocator for the rename stage. Tracks each of `NUM_TAGS` physical tags with a speculative-used bit and a committed-used bit. Offers up to `NUM_UOPS` distinct free tags per cycle to rename, and frees or retains tags on commit. Restores speculative state from committed state on mispredict. Adds an exact registered free count and a sticky protocol-error flag.

## Interface
- `NUM_UOPS`, 4, issue/commit lanes per cycle (1..8)
- `NUM_TAGS`, 64, physical tags; power of two, 8..256
- `TAG_W`, $clog2(NUM_TAGS), tag index width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `IN_mispr`  in  1  mispredict recovery this cycle
- `IN_mispredFlush`  in  1  commit lanes carry replayed/flushed uops
- `IN_issueValid`  in  NUM_UOPS  rename consumes `OUT_issueTags[i]`
- `OUT_issueTags`  out  NUM_UOPS*TAG_W  offered tags, lane i at [i*TAG_W +: TAG_W]
- `OUT_issueTagsValid`  out  NUM_UOPS  lane i offer is valid
- `IN_commitValid`  in  NUM_UOPS  commit lane valid
- `IN_commitNewest`  in  NUM_UOPS  lane is newest writer of its arch reg
- `IN_commitPrevTags`  in  NUM_UOPS*(TAG_W+1)  previous mapping; MSB=1 means no physical tag
- `IN_commitTagDst`  in  NUM_UOPS*(TAG_W+1)  committing uop's tag; MSB=1 means no physical tag
- `OUT_freeCnt`  out  TAG_W+1  tags with spec-used=0, registered
- `OUT_err`  out  1  sticky protocol error

## Operation
- State per tag t: `spec[t]`, `com[t]`. Free for issue iff `spec[t]==0`.
- Offer is combinational from current state. Lane 0 gets the lowest-index free tag, lane 1 the next lowest, and so on. Tags are always distinct.
  - `OUT_issueTagsValid[i] = (OUT_freeCnt > i)`.
  - An invalid lane's tag value is don't-care; drive 0.
- Next-state for `spec`/`com` is built in this order, with later steps overriding earlier ones on the same tag:
  1. If `IN_mispr`: `spec[t] <= com[t]` for all t. Otherwise, for each i with `IN_issueValid[i] && OUT_issueTagsValid[i]`, set `spec[OUT_issueTags[i]]`.
  2. Commit lanes in ascending i, only where `IN_commitValid[i]`:
     - If `IN_mispredFlush`: when `!IN_mispr` and dst valid, set `spec[dst]` (re-reserve for replay). `com` is unchanged.
     - Else if `IN_commitNewest[i]`: when prev valid, clear `spec[prev]` and `com[prev]`. Then, when dst valid, set `spec[dst]` and `com[dst]`.
     - Else (overwritten before commit): when dst valid, clear `spec[dst]` and `com[dst]`.
- `OUT_freeCnt <=` popcount of ~next `spec`. It is exact every cycle, with no incremental drift.
- `OUT_err` is set and held until reset on any of:
  - `IN_issueValid[i] && !OUT_issueTagsValid[i]`; that issue is also ignored.
  - A newest-commit prev tag with `com[prev]==0`.
  - A newest-commit dst tag with `com[dst]==1`.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - All `spec`/`com` = 0, `OUT_freeCnt` = NUM_TAGS, `OUT_err` = 0.
  - Offers are 0,1,..,NUM_UOPS-1, all valid.
- Issue-to-state latency is 1 cycle. A tag consumed at edge N is not offered in cycle N+1. `OUT_freeCnt` reflects it in N+1.
- Freed tags are offerable the cycle after the commit edge. There is no same-cycle bypass.
- Mispredict and issue in the same cycle: issue is dropped and does not raise an error.
- Mispredict with flush commits in the same cycle: flush re-reservation is suppressed.
- Freeing and allocating the same tag in one cycle: the commit action wins.
- Full (`OUT_freeCnt < NUM_UOPS`): only the lower lanes are valid. At 0 free, all lanes are invalid.
- Reset asserted mid-operation clears state immediately and asynchronously.

## Test plan
- Reset, then issue all 4 lanes each cycle for 16 cycles, NUM_TAGS=64 -> tags 0..63 issued exactly once in ascending order; `OUT_freeCnt` steps 60,56,..,0; all lanes invalid afterward; `OUT_err`=0.
- With 2 tags free, assert `IN_issueValid`=4'b1111 -> lanes 0-1 allocated; `OUT_freeCnt`=0; `OUT_err`=1 and stays 1 until reset.
- Issue tags 0-3, newest-commit dst 0 with prev=none, then mispredict -> next cycle `spec` is {0}, offers are 1,2,3,4, `OUT_freeCnt`=63.
- Newest-commit dst 5, prev 0 (0 committed) -> tag 0 offered next cycle on lane 0; `com[5]`=1; count up by 1.
- Non-newest commit of dst 7 -> tag 7 freed; offered next cycle if lowest.
- Flush commit dst 9 without mispr -> tag 9 not offered next cycle. Same stimulus with `IN_mispr`=1 -> tag 9 free after restore.

Source files
------------

// File: rtl/tag_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tag_free_list
// Purpose  : Physical-register tag allocator for rename. Tracks speculative
//            and committed use of every tag, offers the lowest free tags each
//            cycle, retires/frees tags on commit, restores on mispredict and
//            keeps an exact registered free count plus a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tag_free_list #(
   parameter int NUM_UOPS = 4,
   parameter int NUM_TAGS = 64,
   parameter int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        IN_mispr,
   input  logic                        IN_mispredFlush,
   input  logic [NUM_UOPS-1:0]         IN_issueValid,
   output logic [NUM_UOPS*TAG_W-1:0]   OUT_issueTags,
   output logic [NUM_UOPS-1:0]         OUT_issueTagsValid,
   input  logic [NUM_UOPS-1:0]         IN_commitValid,
   input  logic [NUM_UOPS-1:0]         IN_commitNewest,
   input  logic [NUM_UOPS*(TAG_W+1)-1:0] IN_commitPrevTags,
   input  logic [NUM_UOPS*(TAG_W+1)-1:0] IN_commitTagDst,
   output logic [TAG_W:0]              OUT_freeCnt,
   output logic                        OUT_err
);

   localparam logic [TAG_W:0] c_ALL_FREE = (TAG_W+1)'(NUM_TAGS);

   logic [NUM_TAGS-1:0]       r_spec;
   logic [NUM_TAGS-1:0]       r_com;
   logic [TAG_W:0]            r_free_cnt;
   logic                      r_err;

   logic [NUM_UOPS*TAG_W-1:0] w_issue_tags;
   logic [NUM_UOPS-1:0]       w_issue_valid;
   logic [TAG_W:0]            w_scan_cnt;
   logic [NUM_TAGS-1:0]       w_spec_nx;
   logic [NUM_TAGS-1:0]       w_com_nx;
   logic [TAG_W:0]            w_free_nx;
   logic                      w_err_evt;
   logic [TAG_W:0]            w_prev;
   logic [TAG_W:0]            w_dst;

   // Scan tags from low to high; the k-th free tag found goes to lane k.
   always_comb begin
      w_issue_tags = '0;
      w_scan_cnt   = '0;
      for (int t = 0; t < NUM_TAGS; t++) begin
         if (!r_spec[t]) begin
            for (int i = 0; i < NUM_UOPS; i++) begin
               if (w_scan_cnt == (TAG_W+1)'(i)) begin
                  w_issue_tags[i*TAG_W +: TAG_W] = TAG_W'(t);
               end
            end
            w_scan_cnt = w_scan_cnt + 1'b1;
         end
      end
   end

   // A lane is valid exactly when at least lane+1 tags are free; the registered
   // count always equals the popcount of free tags, so this matches the scan.
   generate
      for (genvar g = 0; g < NUM_UOPS; g++) begin : g_lane_valid
         assign w_issue_valid[g] = (r_free_cnt > (TAG_W+1)'(g));
      end
   endgenerate

   // Next-state: recovery/issue first, then commit lanes in order so that a
   // commit action on a tag overrides an allocation of it in the same cycle.
   always_comb begin
      w_spec_nx = r_spec;
      w_com_nx  = r_com;
      w_err_evt = 1'b0;
      w_prev    = '0;
      w_dst     = '0;

      if (IN_mispr) begin
         w_spec_nx = r_com;
      end else begin
         for (int i = 0; i < NUM_UOPS; i++) begin
            if (IN_issueValid[i]) begin
               if (w_issue_valid[i]) begin
                  w_spec_nx[w_issue_tags[i*TAG_W +: TAG_W]] = 1'b1;
               end else begin
                  w_err_evt = 1'b1;
               end
            end
         end
      end

      for (int i = 0; i < NUM_UOPS; i++) begin
         w_prev = IN_commitPrevTags[i*(TAG_W+1) +: (TAG_W+1)];
         w_dst  = IN_commitTagDst[i*(TAG_W+1) +: (TAG_W+1)];
         if (IN_commitValid[i]) begin
            if (IN_mispredFlush) begin
               // Replayed uop keeps its destination reserved unless we are
               // rolling back to committed state anyway.
               if (!IN_mispr && !w_dst[TAG_W]) begin
                  w_spec_nx[w_dst[TAG_W-1:0]] = 1'b1;
               end
            end else if (IN_commitNewest[i]) begin
               if (!w_prev[TAG_W]) begin
                  if (!r_com[w_prev[TAG_W-1:0]]) begin
                     w_err_evt = 1'b1;
                  end
                  w_spec_nx[w_prev[TAG_W-1:0]] = 1'b0;
                  w_com_nx[w_prev[TAG_W-1:0]]  = 1'b0;
               end
               if (!w_dst[TAG_W]) begin
                  if (r_com[w_dst[TAG_W-1:0]]) begin
                     w_err_evt = 1'b1;
                  end
                  w_spec_nx[w_dst[TAG_W-1:0]] = 1'b1;
                  w_com_nx[w_dst[TAG_W-1:0]]  = 1'b1;
               end
            end else begin
               // Destination was overwritten before commit: nobody reads it.
               if (!w_dst[TAG_W]) begin
                  w_spec_nx[w_dst[TAG_W-1:0]] = 1'b0;
                  w_com_nx[w_dst[TAG_W-1:0]]  = 1'b0;
               end
            end
         end
      end
   end

   // Exact popcount of free tags in the next state, recomputed every cycle.
   always_comb begin
      w_free_nx = '0;
      for (int t = 0; t < NUM_TAGS; t++) begin
         if (!w_spec_nx[t]) begin
            w_free_nx = w_free_nx + 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_spec     <= '0;
         r_com      <= '0;
         r_free_cnt <= c_ALL_FREE;
         r_err      <= 1'b0;
      end else begin
         r_spec     <= w_spec_nx;
         r_com      <= w_com_nx;
         r_free_cnt <= w_free_nx;
         r_err      <= r_err | w_err_evt;
      end
   end

   assign OUT_issueTags      = w_issue_tags;
   assign OUT_issueTagsValid = w_issue_valid;
   assign OUT_freeCnt        = r_free_cnt;
   assign OUT_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tag_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_free_list
// Purpose  : Self-checking bench for tag_free_list (4 lanes, 64 tags).
//            Expected results are queued with the stimulus and compared after
//            the DUT reacts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tag_free_list;

   localparam int c_UOPS = 4;
   localparam int c_TAGS = 64;
   localparam int c_TW   = 6;
   localparam logic [c_TW:0] c_NONE = 7'h40;

   logic                        clk;
   logic                        rst;
   logic                        mispr;
   logic                        flush;
   logic [c_UOPS-1:0]           issue_valid;
   logic [c_UOPS*c_TW-1:0]      issue_tags;
   logic [c_UOPS-1:0]           issue_tags_valid;
   logic [c_UOPS-1:0]           commit_valid;
   logic [c_UOPS-1:0]           commit_newest;
   logic [c_UOPS*(c_TW+1)-1:0]  commit_prev;
   logic [c_UOPS*(c_TW+1)-1:0]  commit_dst;
   logic [c_TW:0]               free_cnt;
   logic                        err;

   typedef struct {
      string       nm;
      int          sel;    // 0 lane tag, 1 valid vector, 2 free count, 3 err
      int          lane;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   tag_free_list #(.NUM_UOPS(c_UOPS), .NUM_TAGS(c_TAGS), .TAG_W(c_TW)) u_dut (
      .clk               (clk),
      .rst               (rst),
      .IN_mispr          (mispr),
      .IN_mispredFlush   (flush),
      .IN_issueValid     (issue_valid),
      .OUT_issueTags     (issue_tags),
      .OUT_issueTagsValid(issue_tags_valid),
      .IN_commitValid    (commit_valid),
      .IN_commitNewest   (commit_newest),
      .IN_commitPrevTags (commit_prev),
      .IN_commitTagDst   (commit_dst),
      .OUT_freeCnt       (free_cnt),
      .OUT_err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel, input int lane);
      case (sel)
         0:       observe = 32'(issue_tags[lane*c_TW +: c_TW]);
         1:       observe = 32'(issue_tags_valid);
         2:       observe = 32'(free_cnt);
         default: observe = 32'(err);
      endcase
   endfunction

   task automatic push(input string nm, input int sel, input int lane, input int val);
      exp_t e;
      e.nm = nm; e.sel = sel; e.lane = lane; e.val = 32'(val);
      sb.push_back(e);
   endtask

   task automatic exp_offers(input string nm, input int t0, input int t1,
                             input int t2, input int t3, input int vmask);
      push({nm, ".lane0"}, 0, 0, t0);
      push({nm, ".lane1"}, 0, 1, t1);
      push({nm, ".lane2"}, 0, 2, t2);
      push({nm, ".lane3"}, 0, 3, t3);
      push({nm, ".valid"}, 1, 0, vmask);
   endtask

   task automatic exp_state(input string nm, input int cnt, input int e);
      push({nm, ".cnt"}, 2, 0, cnt);
      push({nm, ".err"}, 3, 0, e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.nm, observe(e.sel, e.lane), e.val);
      end
   endtask

   task automatic clr_inputs();
      mispr = 1'b0; flush = 1'b0; issue_valid = '0;
      commit_valid = '0; commit_newest = '0;
      commit_prev = {c_UOPS{c_NONE}}; commit_dst = {c_UOPS{c_NONE}};
   endtask

   task automatic set_commit(input int lane, input logic newest,
                             input logic [c_TW:0] prev, input logic [c_TW:0] dst);
      commit_valid[lane]  = 1'b1;
      commit_newest[lane] = newest;
      commit_prev[lane*(c_TW+1) +: (c_TW+1)] = prev;
      commit_dst[lane*(c_TW+1) +: (c_TW+1)]  = dst;
   endtask

   // Apply the driven inputs on one edge, check queued results, idle inputs.
   task automatic cycle();
      @(posedge clk);
      #1;
      drain();
      clr_inputs();
   endtask

   // Reset asserted mid-cycle; its effect must be visible before any edge.
   task automatic do_reset(input string nm);
      #2 rst = 1'b0;
      #1;
      exp_state({nm, ".async"}, 64, 0);
      exp_offers({nm, ".async"}, 0, 1, 2, 3, 4'hF);
      drain();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clr_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state
      exp_state("reset", 64, 0);
      exp_offers("reset", 0, 1, 2, 3, 4'hF);
      drain();

      // Drain the whole pool four lanes at a time
      for (int c = 0; c < 16; c++) begin
         exp_offers($sformatf("walk%0d", c), 4*c, 4*c+1, 4*c+2, 4*c+3, 4'hF);
         drain();
         issue_valid = 4'hF;
         exp_state($sformatf("walk%0d", c), 60 - 4*c, 0);
         if (c == 15) exp_offers("empty", 0, 0, 0, 0, 4'h0);
         cycle();
      end
      exp_state("empty.idle", 0, 0);
      exp_offers("empty.idle", 0, 0, 0, 0, 4'h0);
      cycle();

      // Over-issue with two free tags
      do_reset("rst1");
      for (int c = 0; c < 15; c++) begin
         issue_valid = 4'hF;
         cycle();
      end
      exp_offers("two.pre", 60, 61, 62, 63, 4'hF);
      drain();
      issue_valid = 4'b0011;
      exp_state("two", 2, 0);
      exp_offers("two", 62, 63, 0, 0, 4'b0011);
      cycle();
      issue_valid = 4'hF;
      exp_state("overissue", 0, 1);
      exp_offers("overissue", 0, 0, 0, 0, 4'h0);
      cycle();
      exp_state("err.sticky", 0, 1);
      cycle();

      // Commit tag 0 then mispredict restores spec from com
      do_reset("rst2");
      issue_valid = 4'hF;
      cycle();
      set_commit(0, 1'b1, c_NONE, 7'd0);
      exp_state("commit0", 60, 0);
      cycle();
      mispr = 1'b1;
      exp_state("mispr", 63, 0);
      exp_offers("mispr", 1, 2, 3, 4, 4'hF);
      cycle();

      // Newest commit dst 5 frees prev 0
      issue_valid = 4'hF;
      cycle();
      issue_valid = 4'b0001;
      exp_state("take5", 58, 0);
      exp_offers("take5", 6, 7, 8, 9, 4'hF);
      cycle();
      set_commit(0, 1'b1, 7'd0, 7'd5);
      exp_state("free0", 59, 0);
      exp_offers("free0", 0, 6, 7, 8, 4'hF);
      cycle();
      mispr = 1'b1;
      exp_state("com5", 63, 0);
      exp_offers("com5", 0, 1, 2, 3, 4'hF);
      cycle();

      // Non-newest commit of dst 7 frees it
      issue_valid = 4'hF;
      cycle();
      issue_valid = 4'hF;
      exp_state("fill8", 55, 0);
      exp_offers("fill8", 9, 10, 11, 12, 4'hF);
      cycle();
      set_commit(0, 1'b0, c_NONE, 7'd7);
      exp_state("kill7", 56, 0);
      exp_offers("kill7", 7, 9, 10, 11, 4'hF);
      cycle();

      // Flush commit re-reserves dst 9, but not alongside a mispredict
      flush = 1'b1;
      set_commit(0, 1'b1, c_NONE, 7'd9);
      exp_state("flush9", 55, 0);
      exp_offers("flush9", 7, 10, 11, 12, 4'hF);
      cycle();
      flush = 1'b1;
      mispr = 1'b1;
      set_commit(0, 1'b1, c_NONE, 7'd9);
      exp_state("flush9.mispr", 63, 0);
      exp_offers("flush9.mispr", 0, 1, 2, 3, 4'hF);
      cycle();

      // Same-cycle allocate and free of tag 0: commit wins
      issue_valid = 4'b0001;
      set_commit(1, 1'b0, c_NONE, 7'd0);
      exp_state("alloc.free", 63, 0);
      exp_offers("alloc.free", 0, 1, 2, 3, 4'hF);
      cycle();

      // Mispredict with issue: issue dropped, no error
      mispr = 1'b1;
      issue_valid = 4'hF;
      exp_state("mispr.issue", 63, 0);
      exp_offers("mispr.issue", 0, 1, 2, 3, 4'hF);
      cycle();

      // Protocol error: prev not committed
      set_commit(0, 1'b1, 7'd1, c_NONE);
      exp_state("err.prev", 63, 1);
      cycle();
      do_reset("rst3");

      // Protocol error: dst already committed
      set_commit(2, 1'b1, c_NONE, 7'd2);
      exp_state("dst2", 63, 0);
      exp_offers("dst2", 0, 1, 3, 4, 4'hF);
      cycle();
      set_commit(0, 1'b1, c_NONE, 7'd2);
      exp_state("err.dst", 63, 1);
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
